// File: rtl/fft5_pkg.sv
// rtl/fft5_pkg.sv - shared constants, read-FSM encoding and frame-length helpers for the FFT5 feeder
package fft5_pkg;

  localparam int FFT5_N5  = 5;
  localparam int FFT5_N25 = 25;

  localparam logic [1:0] ST_5  = 2'd1;
  localparam logic [1:0] ST_25 = 2'd2;

  typedef logic [1:0] rd_state_t;
  localparam rd_state_t RD_IDLE  = 2'd0;
  localparam rd_state_t RD_BURST = 2'd1;
  localparam rd_state_t RD_GAP   = 2'd2;

  function automatic logic [4:0] fn_frame_len(input logic [1:0] st);
    case (st)
      ST_5:    return 5'(FFT5_N5);
      ST_25:   return 5'(FFT5_N25);
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic fn_stages_ok(input logic [1:0] st);
    return (st == ST_5) || (st == ST_25);
  endfunction

endpackage

// File: rtl/feeder_bank.sv
// rtl/feeder_bank.sv - one frame bank: single write port, registered read port that returns 0 when idle
module feeder_bank #(
  parameter int W     = 36,
  parameter int DEPTH = 25,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Clearing on idle lets the top OR both banks together instead of muxing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
    else           rdata_q <= '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft5_frame_feeder.sv
// rtl/fft5_frame_feeder.sv - ping-pong frame assembler emitting contiguous FFT5 input bursts
// Optional feature macro: FEEDER_CONJ_EN (conjugate frames tagged inv=1 on the read path).
module fft5_frame_feeder
  import fft5_pkg::*;
#(
  parameter int WIDTH   = 18,
  parameter int MIN_GAP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       stages,
  input  logic             inv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic [1:0]       do_stages
);

  localparam int DW = 2 * WIDTH;

  logic [1:0]      full_q, full_d;
  logic            wr_bank_q, wr_bank_d;
  logic [4:0]      wr_cnt_q, wr_cnt_d;
  logic [1:0][1:0] tag_st_q, tag_st_d;
  logic            rd_bank_q, rd_bank_d;
  logic [4:0]      rd_idx_q, rd_idx_d;
  rd_state_t       state_q, state_d;
  logic [15:0]     gap_q, gap_d;
  logic            do_en_q, do_en_d;
  logic [1:0]      do_stages_q, do_stages_d;

  logic [4:0] wr_len, rd_len, emit_idx;
  logic       wr_acc, wr_last, start, emit, rd_last;
  logic [DW-1:0] rd_data [2];
  logic [DW-1:0] rd_word;
  logic [WIDTH-1:0] rd_im;

  // Frame length comes from the live stages input only for the first sample.
  always_comb begin
    wr_len   = (wr_cnt_q == 5'd0) ? fn_frame_len(stages) : fn_frame_len(tag_st_q[wr_bank_q]);
    in_ready = !flush && !full_q[wr_bank_q] && ((wr_cnt_q != 5'd0) || fn_stages_ok(stages));
    wr_acc   = in_valid && in_ready;
    wr_last  = wr_acc && (wr_cnt_q == wr_len - 5'd1);
  end

  always_comb begin
    rd_len   = fn_frame_len(tag_st_q[rd_bank_q]);
    start    = (state_q == RD_IDLE) && full_q[rd_bank_q];
    emit     = start || (state_q == RD_BURST);
    emit_idx = start ? 5'd0 : rd_idx_q;
    rd_last  = emit && (emit_idx == rd_len - 5'd1);
  end

  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    tag_st_d    = tag_st_q;
    rd_bank_d   = rd_bank_q;
    rd_idx_d    = rd_idx_q;
    state_d     = state_q;
    gap_d       = gap_q;
    do_en_d     = emit;
    do_stages_d = start ? tag_st_q[rd_bank_q] : do_stages_q;

    if (wr_acc) begin
      if (wr_cnt_q == 5'd0) tag_st_d[wr_bank_q] = stages;
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_cnt_d          = 5'd0;
        wr_bank_d         = !wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 5'd1;
      end
    end

    case (state_q)
      RD_IDLE: begin
        if (start) begin
          state_d  = RD_BURST;
          rd_idx_d = 5'd1;
        end
      end
      RD_BURST: rd_idx_d = rd_idx_q + 5'd1;
      RD_GAP: begin
        gap_d = gap_q + 16'd1;
        if (int'(gap_q) + 1 >= MIN_GAP) begin
          state_d = RD_IDLE;
          gap_d   = 16'd0;
        end
      end
      default: state_d = RD_IDLE;
    endcase

    // Write and release never target the same bank: writes need !full, release needs full.
    if (rd_last) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
      rd_idx_d          = 5'd0;
      state_d           = (MIN_GAP > 0) ? RD_GAP : RD_IDLE;
    end

    if (flush) begin
      full_d      = 2'b00;
      wr_cnt_d    = 5'd0;
      wr_bank_d   = 1'b0;
      rd_bank_d   = 1'b0;
      rd_idx_d    = 5'd0;
      state_d     = RD_IDLE;
      gap_d       = 16'd0;
      do_en_d     = 1'b0;
      do_stages_d = do_stages_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q      <= 2'b00;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= 5'd0;
      tag_st_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= 5'd0;
      state_q     <= RD_IDLE;
      gap_q       <= 16'd0;
      do_en_q     <= 1'b0;
      do_stages_q <= 2'd0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      tag_st_q    <= tag_st_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      state_q     <= state_d;
      gap_q       <= gap_d;
      do_en_q     <= do_en_d;
      do_stages_q <= do_stages_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    feeder_bank #(.W(DW), .DEPTH(FFT5_N25), .AW(5)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_acc && (wr_bank_q == 1'(b))),
      .waddr_i (wr_cnt_q),
      .wdata_i ({in_re, in_im}),
      .re_i    (emit && !flush && (rd_bank_q == 1'(b))),
      .raddr_i (emit_idx),
      .rdata_o (rd_data[b])
    );
  end

  assign rd_word   = rd_data[0] | rd_data[1];
  assign rd_im     = rd_word[WIDTH-1:0];
  assign do_re     = rd_word[DW-1:WIDTH];
  assign do_en     = do_en_q;
  assign do_stages = do_stages_q;

`ifdef FEEDER_CONJ_EN
  localparam logic [WIDTH-1:0] IM_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] IM_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  logic [1:0] tag_inv_q;
  logic       do_inv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_inv_q <= 2'b00;
      do_inv_q  <= 1'b0;
    end else begin
      if (wr_acc && (wr_cnt_q == 5'd0)) tag_inv_q[wr_bank_q] <= inv;
      if (start && !flush)              do_inv_q <= tag_inv_q[rd_bank_q];
    end
  end

  // Negating the most negative value saturates instead of wrapping back to itself.
  assign do_im = !do_inv_q ? rd_im : (rd_im == IM_MIN) ? IM_MAX : (-rd_im);
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign do_im      = rd_im;
`endif

endmodule

// File: tb/tb_fft5_frame_feeder.sv
// tb/tb_fft5_frame_feeder.sv - frame-assembly reference model and burst scoreboard for fft5_frame_feeder
module tb_fft5_frame_feeder;

  localparam int W = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic inv = 1'b0;
  logic in_valid = 1'b0;
  logic [1:0] stages = 2'd1;
  logic [W-1:0] in_re = '0;
  logic [W-1:0] in_im = '0;
  logic in_ready, do_en;
  logic [W-1:0] do_re, do_im;
  logic [1:0] do_stages;

  fft5_frame_feeder #(.WIDTH(W), .MIN_GAP(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stages(stages), .inv(inv),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .do_en(do_en), .do_re(do_re), .do_im(do_im), .do_stages(do_stages)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: frames assembled from accepted samples, emitted in order.
  logic [W-1:0] exp_re[$], exp_im[$], part_re[$], part_im[$];
  int           exp_len[$];
  logic [1:0]   exp_st[$];
  int           part_len = 0;
  logic [1:0]   part_st = 2'd0;
  logic         part_inv = 1'b0;
  int           starts[$];
  int           mon_cnt = 0, mon_len = 0, last_acc = 0, rdy_low = 0;

`ifdef FEEDER_CONJ_EN
  function automatic logic [W-1:0] conj_im(input logic [W-1:0] im, input logic iv);
    logic [W-1:0] mn, mx;
    mn = {1'b1, {(W-1){1'b0}}};
    mx = {1'b0, {(W-1){1'b1}}};
    if (!iv) return im;
    if (im == mn) return mx;
    return W'(0 - int'(signed'(im)));
  endfunction
`else
  function automatic logic [W-1:0] conj_im(input logic [W-1:0] im, input logic iv_unused);
    return im;
  endfunction
`endif

  task automatic model_accept(input logic [W-1:0] re, input logic [W-1:0] im,
                              input logic [1:0] st, input logic iv);
    if (part_re.size() == 0) begin
      part_len = (st == 2'd1) ? 5 : 25;
      part_st  = st;
      part_inv = iv;
    end
    part_re.push_back(re);
    part_im.push_back(conj_im(im, part_inv));
    if (part_re.size() == part_len) begin
      while (part_re.size() > 0) begin
        exp_re.push_back(part_re.pop_front());
        exp_im.push_back(part_im.pop_front());
      end
      exp_len.push_back(part_len);
      exp_st.push_back(part_st);
    end
  endtask

  task automatic model_flush();
    exp_re.delete(); exp_im.delete(); exp_len.delete(); exp_st.delete();
    part_re.delete(); part_im.delete();
    mon_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (do_en) begin
        if (mon_cnt == 0) begin
          starts.push_back(cyc);
          chk("frame_pending", exp_len.size() > 0, 1);
          if (exp_len.size() > 0) begin
            mon_len = exp_len.pop_front();
            chk("do_stages", do_stages, exp_st.pop_front());
          end
        end
        chk("sample_pending", exp_re.size() > 0, 1);
        if (exp_re.size() > 0) begin
          chk("do_re", do_re, exp_re.pop_front());
          chk("do_im", do_im, exp_im.pop_front());
        end
        mon_cnt++;
        if (mon_cnt >= mon_len) mon_cnt = 0;
      end else begin
        chk("burst_contiguous", mon_cnt, 0);
        chk("idle_data_zero", {do_re, do_im}, 0);
        mon_cnt = 0;
      end
    end
  end

  task automatic cyc_drive(input logic v, input logic [W-1:0] re, input logic [W-1:0] im,
                           input logic [1:0] st, input logic iv, input logic fl, output logic acc);
    in_valid = v; in_re = re; in_im = im; stages = st; inv = iv; flush = fl;
    @(negedge clk);
    acc = v && in_ready;
    if (v && !in_ready && !fl) rdy_low++;
    @(posedge clk);
    #1;
    if (acc) begin
      model_accept(re, im, st, iv);
      last_acc = cyc;
    end
    if (fl) model_flush();
  endtask

  task automatic idle_cycle();
    logic a;
    cyc_drive(1'b0, '0, '0, 2'd1, 1'b0, 1'b0, a);
  endtask

  task automatic send(input string name, input int n, input int base,
                      input logic [1:0] st0, input logic [1:0] st1, input int sw, input logic iv);
    int k, budget;
    logic a;
    k = 0; budget = 0;
    while (k < n && budget < 400) begin
      cyc_drive(1'b1, W'(base + k), W'(-(base + k)), (k < sw) ? st0 : st1, iv, 1'b0, a);
      if (a) k++;
      budget++;
    end
    chk({"sent_", name}, k, n);
  endtask

  task automatic drain(input string name);
    int b;
    b = 0;
    while ((exp_re.size() != 0 || mon_cnt != 0) && b < 200) begin
      idle_cycle();
      b++;
    end
    chk({"drained_", name}, exp_re.size() + mon_cnt, 0);
  endtask

  typedef struct {
    logic [1:0] st;
    logic       fl;
    logic       exp_rdy;
  } rdy_vec_t;

  initial begin : main
    rdy_vec_t tbl[6];
    logic a;
    int b, k, acc_at;
    tbl[0] = '{2'd0, 1'b0, 1'b0};
    tbl[1] = '{2'd1, 1'b0, 1'b1};
    tbl[2] = '{2'd2, 1'b0, 1'b1};
    tbl[3] = '{2'd3, 1'b0, 1'b0};
    tbl[4] = '{2'd1, 1'b1, 1'b0};
    tbl[5] = '{2'd2, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_do_en_held", do_en, 0);
    rst = 1'b0;
    #1;
    chk("rst_do_en", do_en, 0);
    chk("rst_do_re", do_re, 0);
    chk("rst_do_im", do_im, 0);
    chk("rst_do_stages", do_stages, 0);
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 6; i++) begin
      stages = tbl[i].st;
      flush  = tbl[i].fl;
      #1;
      chk($sformatf("ready_tbl%0d", i), in_ready, tbl[i].exp_rdy);
    end
    flush = 1'b0; stages = 2'd1;
    @(posedge clk);
    #1;

    // Single 5-point frame: order, tag and one-cycle latency.
    starts.delete();
    send("t1", 5, 1, 2'd1, 2'd1, 99, 1'b0);
    acc_at = last_acc;
    drain("t1");
    chk("t1_bursts", starts.size(), 1);
    if (starts.size() > 0) chk("t1_latency", starts[0] - acc_at, 1);
    chk("t1_stages_held", do_stages, 1);
    chk("t1_do_en_low", do_en, 0);

    // Two 25-point frames back to back.
    starts.delete();
    send("t4a", 25, 100, 2'd2, 2'd2, 99, 1'b0);
    send("t4b", 25, 200, 2'd2, 2'd2, 99, 1'b0);
    drain("t4");
    chk("t4_bursts", starts.size(), 2);
    if (starts.size() == 2) chk("t4_back_to_back", starts[1] - starts[0], 25);

    // Mid-frame stages change is ignored.
    starts.delete();
    send("t6", 5, 300, 2'd1, 2'd2, 3, 1'b0);
    drain("t6");
    chk("t6_bursts", starts.size(), 1);
    chk("t6_stages", do_stages, 1);

    // Continuous upstream while a long burst holds a bank.
    rdy_low = 0;
    send("t5a", 25, 400, 2'd2, 2'd2, 99, 1'b0);
    for (int f = 0; f < 6; f++) send($sformatf("t5_%0d", f), 5, 500 + 10 * f, 2'd1, 2'd1, 99, 1'b0);
    drain("t5");
    chk("t5_backpressure", rdy_low > 0, 1);

    // Flush at sample 10 of a 25-point burst with the other bank partly filled.
    send("t7a", 25, 600, 2'd2, 2'd2, 99, 1'b0);
    k = 0; b = 0;
    while (mon_cnt < 10 && b < 100) begin
      cyc_drive(1'b1, W'(700 + k), W'(-(700 + k)), 2'd2, 1'b0, 1'b0, a);
      if (a) k++;
      b++;
    end
    chk("t7_reached_sample10", mon_cnt, 10);
    cyc_drive(1'b1, W'(777), W'(5), 2'd1, 1'b0, 1'b1, a);
    chk("t7_ready_in_flush", a, 0);
    chk("t7_do_en", do_en, 0);
    chk("t7_do_re", do_re, 0);
    chk("t7_do_im", do_im, 0);
    flush = 1'b0; in_valid = 1'b0; stages = 2'd1;
    #1;
    chk("t7_ready_after", in_ready, 1);
    starts.delete();
    send("t7c", 5, 800, 2'd1, 2'd1, 99, 1'b0);
    drain("t7");
    chk("t7_bursts", starts.size(), 1);

    // Asynchronous reset in the middle of a burst.
    send("t8a", 25, 900, 2'd2, 2'd2, 99, 1'b0);
    b = 0;
    while (mon_cnt < 5 && b < 100) begin
      idle_cycle();
      b++;
    end
    rst = 1'b1;
    #1;
    chk("t8_rst_do_en", do_en, 0);
    chk("t8_rst_do_re", do_re, 0);
    model_flush();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send("t8b", 5, 950, 2'd1, 2'd1, 99, 1'b0);
    drain("t8");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [1:0] st;
      r = $urandom_range(0, 9);
      st = (r < 4) ? 2'd1 : (r < 8) ? 2'd2 : (r == 8) ? 2'd0 : 2'd3;
      cyc_drive($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), st,
                1'($urandom_range(0, 1)), $urandom_range(0, 149) == 0, a);
    end
    drain("rand");
    cyc_drive(1'b0, '0, '0, 2'd1, 1'b0, 1'b1, a);
    flush = 1'b0;

`ifdef FEEDER_CONJ_EN
    begin
      logic [W-1:0] ims[5];
      ims[0] = {1'b1, {(W-1){1'b0}}};
      ims[1] = W'(7);
      ims[2] = W'(0);
      ims[3] = W'(-1);
      ims[4] = W'(-5);
      for (int pass = 0; pass < 2; pass++) begin
        k = 0; b = 0;
        while (k < 5 && b < 50) begin
          cyc_drive(1'b1, W'(k), ims[k], 2'd1, (pass == 0), 1'b0, a);
          if (a) k++;
          b++;
        end
        drain($sformatf("conj%0d", pass));
      end
    end
`endif

    idle_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, %0d of %0d checks failed", n_err, n_vec);
    $fatal(1);
  end

endmodule
